de0_onchip_mem_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter that shares the single-port 1024×32 on-chip RAM (byte-enabled, one-cycle read latency) between two masters, e.g. the CPU data master and a DMA engine. It grants one transfer per clock, applies a run-limited round-robin policy, and returns read data with `readdatavalid` to the issuing requester. It sits between the system interconnect and the RAM's s1 port.

---
 rtl/de0_onchip_mem_arbiter_pkg.sv | 22 ++
 rtl/de0_onchip_mem_arbiter_if.sv | 55 +++++
 rtl/de0_onchip_mem_arbiter_rr2_run_grant.sv | 77 +++++++
 rtl/de0_onchip_mem_arbiter.sv | 104 ++++++++++
 tb/tb_de0_onchip_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/de0_onchip_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_arb_pkg
// Shared constants and types for the two-requester on-chip RAM arbiter.
//   ADDR_W : word address width (1024 words)
//   DATA_W : data width
//   BE_W   : byte-enable width
//   RUN_W  : width of the run-length counter (saturates at 15)
//   owner_t: identifies which requester owns a grant or a pending read
// -----------------------------------------------------------------------------
package onchip_mem_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int RUN_W  = 4;

    typedef enum logic {
        R0 = 1'b0,
        R1 = 1'b1
    } owner_t;

endpackage

// File: rtl/de0_onchip_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// de0_onchip_mem_arbiter_if
// Bundles both Avalon-MM requester ports and the RAM s1-side port.
//   rN_*  : requester N (address, byteenable, read, write, writedata in;
//           waitrequest, readdata, readdatavalid out of the arbiter)
//   mem_* : RAM side (address, byteenable, chipselect, write, writedata,
//           clken out of the arbiter; readdata back from the RAM)
// Modports:
//   slave  : the arbiter
//   master : the system side that drives requests and models the RAM
// -----------------------------------------------------------------------------
interface de0_onchip_mem_arbiter_if #(
    parameter int ADDR_W = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W = onchip_mem_arb_pkg::DATA_W
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] r0_address,    r1_address;
    logic [BE_W-1:0]   r0_byteenable, r1_byteenable;
    logic              r0_read,       r1_read;
    logic              r0_write,      r1_write;
    logic [DATA_W-1:0] r0_writedata,  r1_writedata;
    logic              r0_waitrequest,   r1_waitrequest;
    logic [DATA_W-1:0] r0_readdata,      r1_readdata;
    logic              r0_readdatavalid, r1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  r0_address, r0_byteenable, r0_read, r0_write, r0_writedata,
        input  r1_address, r1_byteenable, r1_read, r1_write, r1_writedata,
        output r0_waitrequest, r0_readdata, r0_readdatavalid,
        output r1_waitrequest, r1_readdata, r1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    modport master (
        output r0_address, r0_byteenable, r0_read, r0_write, r0_writedata,
        output r1_address, r1_byteenable, r1_read, r1_write, r1_writedata,
        input  r0_waitrequest, r0_readdata, r0_readdatavalid,
        input  r1_waitrequest, r1_readdata, r1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface

// File: rtl/de0_onchip_mem_arbiter_rr2_run_grant.sv
// -----------------------------------------------------------------------------
// rr2_run_grant
// Two-way run-limited round-robin. The previous owner keeps the RAM while the
// other side also requests, until it has held it MAX_RUN consecutive times.
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : request from requester 1/0
//   grant[1:0]   : one-hot grant, combinational within the cycle
// -----------------------------------------------------------------------------
module rr2_run_grant #(
    parameter int MAX_RUN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    import onchip_mem_arb_pkg::*;

    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_SAT   = '1;

    owner_t            last_q,    last_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              busy_q,    busy_d;   // a grant happened last cycle
    owner_t            owner;
    logic              any_req;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= R0;
            run_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            last_q    <= last_d;
            run_cnt_q <= run_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Output logic: pick the owner for this cycle.
    // NOTE: every variable gets a default at the top of a combinational block
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        owner   = last_q;
        any_req = |req;
        case (req)
            2'b01:   owner = R0;
            2'b10:   owner = R1;
            2'b11:   owner = (run_cnt_q < RUN_LIMIT) ? last_q
                           : ((last_q == R0) ? R1 : R0);
            default: owner = last_q;
        endcase
        grant = 2'b00;
        if (any_req) grant = (owner == R1) ? 2'b10 : 2'b01;
    end

    // Next-state logic. run_cnt is held across idle cycles (it still steers
    // the next contended grant) but restarts at 1 on the first grant after one.
    always_comb begin
        last_d    = last_q;
        run_cnt_d = run_cnt_q;
        busy_d    = any_req;
        if (any_req) begin
            last_d = owner;
            if (!busy_q || owner != last_q) begin
                run_cnt_d = RUN_ONE;
            end else if (run_cnt_q != RUN_SAT) begin
                run_cnt_d = run_cnt_q + RUN_ONE;
            end
        end
    end

endmodule

// File: rtl/de0_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// de0_onchip_mem_arbiter
// Shares the single-port 1024x32 on-chip RAM between two Avalon-MM masters.
// One transfer per clock, run-limited round-robin, one-cycle read return
// routed back to the issuing requester.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : requester ports r0_*/r1_* and RAM port mem_* (slave modport)
// -----------------------------------------------------------------------------
module de0_onchip_mem_arbiter #(
    parameter int ADDR_W  = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = onchip_mem_arb_pkg::DATA_W,
    parameter int MAX_RUN = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    de0_onchip_mem_arbiter_if.slave  bus
);
    import onchip_mem_arb_pkg::*;

    localparam int BYTES = DATA_W / 8;

    logic              active_q;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              rd_accept;
    logic              rd_pend_q,  rd_pend_d;
    owner_t            rd_owner_q, rd_owner_d;
    logic              rdv0, rdv1;
    logic [ADDR_W-1:0] mem_address;
    logic [BYTES-1:0]  mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_write;

    // Requests are ignored until the first edge that sees reset_n high, so the
    // first transfer can only be accepted on the edge after that.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) active_q <= 1'b0;
        else          active_q <= 1'b1;
    end

    assign req = {bus.r1_read | bus.r1_write, bus.r0_read | bus.r0_write}
               & {2{active_q}};

    rr2_run_grant #(.MAX_RUN(MAX_RUN)) u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant)
    );

    // RAM-side mux. A write strobe overrides a simultaneous read strobe.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        rd_accept      = 1'b0;
        if (grant[0]) begin
            mem_address    = bus.r0_address;
            mem_byteenable = bus.r0_byteenable;
            mem_writedata  = bus.r0_writedata;
            mem_write      = bus.r0_write;
            rd_accept      = bus.r0_read & ~bus.r0_write;
        end else if (grant[1]) begin
            mem_address    = bus.r1_address;
            mem_byteenable = bus.r1_byteenable;
            mem_writedata  = bus.r1_writedata;
            mem_write      = bus.r1_write;
            rd_accept      = bus.r1_read & ~bus.r1_write;
        end
    end

    assign bus.mem_address    = mem_address;
    assign bus.mem_byteenable = mem_byteenable;
    assign bus.mem_writedata  = mem_writedata;
    assign bus.mem_write      = mem_write;
    assign bus.mem_chipselect = |grant;
    assign bus.mem_clken      = reset_n;

    // Read-return pipeline: one stage matching the RAM's read latency.
    assign rd_pend_d  = rd_accept;
    assign rd_owner_d = grant[1] ? R1 : R0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= R0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign rdv0 = rd_pend_q & (rd_owner_q == R0);
    assign rdv1 = rd_pend_q & (rd_owner_q == R1);

    assign bus.r0_readdatavalid = rdv0;
    assign bus.r1_readdatavalid = rdv1;
    assign bus.r0_readdata      = rdv0 ? bus.mem_readdata : '0;
    assign bus.r1_readdata      = rdv1 ? bus.mem_readdata : '0;
    assign bus.r0_waitrequest   = ~req[0] | ~grant[0];
    assign bus.r1_waitrequest   = ~req[1] | ~grant[1];

endmodule

// File: tb/tb_de0_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_de0_onchip_mem_arbiter
// Drives both requesters, models the 1024x32 byte-enabled RAM with one-cycle
// read latency, and compares the arbiter against a grant-history model.
// -----------------------------------------------------------------------------
module tb_de0_onchip_mem_arbiter;

    localparam int MAX_RUN = 4;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        req_t        q0;
        req_t        q1;
        bit          w0, w1, v0, v1;
        logic [31:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    de0_onchip_mem_arbiter_if bus ();

    de0_onchip_mem_arbiter #(.MAX_RUN(MAX_RUN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // RAM model on the s1 side.
    // NOTE: the storage array is never reset; only control state has a reset.
    logic [31:0] ram [1024];
    logic [31:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.mem_clken && bus.mem_chipselect) begin
            if (bus.mem_write) ram[bus.mem_address] <= merge(ram[bus.mem_address], bus.mem_writedata, bus.mem_byteenable);
            else               ram_q <= ram[bus.mem_address];
        end
    end
    assign bus.mem_readdata = ram_q;

    // Reference model: history of grant owners per cycle (-1 = idle).
    int          hist[$];
    logic [31:0] mmem [1024];
    bit          pend_v;
    int          pend_o;
    logic [31:0] pend_d;

    function automatic int model_owner(bit q0, bit q1);
        int idx, last, run;
        if (!q0 && !q1) return -1;
        if (q0 && !q1)  return 0;
        if (!q0 && q1)  return 1;
        idx = hist.size() - 1;
        while (idx >= 0 && hist[idx] < 0) idx--;
        if (idx < 0) return 0;
        last = hist[idx];
        run  = 0;
        while (idx >= 0 && hist[idx] == last) begin run++; idx--; end
        if (run > 15) run = 15;
        return (run < MAX_RUN) ? last : 1 - last;
    endfunction

    function automatic req_t mk(bit rd, bit wr, int a, logic [3:0] be, logic [31:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.a = 10'(a); r.be = be; r.wd = wd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input req_t a, input req_t b);
        bus.r0_read = a.rd; bus.r0_write = a.wr; bus.r0_address = a.a;
        bus.r0_byteenable = a.be; bus.r0_writedata = a.wd;
        bus.r1_read = b.rd; bus.r1_write = b.wr; bus.r1_address = b.a;
        bus.r1_byteenable = b.be; bus.r1_writedata = b.wd;
    endtask

    // One clock: drive, compare against the model, then advance the model.
    task automatic step(input req_t a, input req_t b, output int g);
        req_t gr;
        @(negedge clk);
        drive(a, b);
        #1;
        g  = model_owner(a.rd | a.wr, b.rd | b.wr);
        gr = (g == 1) ? b : a;
        check("wait0", bus.r0_waitrequest, g != 0);
        check("wait1", bus.r1_waitrequest, g != 1);
        check("rdv0", bus.r0_readdatavalid, pend_v && pend_o == 0);
        check("rdv1", bus.r1_readdatavalid, pend_v && pend_o == 1);
        check("rdata0", bus.r0_readdata, (pend_v && pend_o == 0) ? pend_d : 32'h0);
        check("rdata1", bus.r1_readdata, (pend_v && pend_o == 1) ? pend_d : 32'h0);
        check("mem_cs", bus.mem_chipselect, g >= 0);
        check("mem_wr", bus.mem_write, g >= 0 && gr.wr);
        check("mem_addr", bus.mem_address, (g >= 0) ? gr.a : 10'h0);
        check("mem_be", bus.mem_byteenable, (g >= 0) ? gr.be : 4'h0);
        check("mem_wd", bus.mem_writedata, (g >= 0) ? gr.wd : 32'h0);
        hist.push_back(g);
        pend_v = (g >= 0) && gr.rd && !gr.wr;
        pend_o = g;
        pend_d = mmem[gr.a];
        if (g >= 0 && gr.wr) mmem[gr.a] = merge(mmem[gr.a], gr.wd, gr.be);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wait0"}, bus.r0_waitrequest, 1);
        check({tag, "_wait1"}, bus.r1_waitrequest, 1);
        check({tag, "_rdv0"}, bus.r0_readdatavalid, 0);
        check({tag, "_rdv1"}, bus.r1_readdatavalid, 0);
        check({tag, "_rdata0"}, bus.r0_readdata, 0);
        check({tag, "_rdata1"}, bus.r1_readdata, 0);
        check({tag, "_cs"}, bus.mem_chipselect, 0);
        check({tag, "_wr"}, bus.mem_write, 0);
        check({tag, "_addr"}, bus.mem_address, 0);
        check({tag, "_be"}, bus.mem_byteenable, 0);
        check({tag, "_wd"}, bus.mem_writedata, 0);
        check({tag, "_clken"}, bus.mem_clken, 0);
    endtask

    // Reset with requests held active to show they are masked.
    task automatic do_reset();
        reset_n = 1'b0;
        drive(mk(1, 0, 1, 4'hF, 32'h1), mk(1, 1, 2, 4'h3, 32'h2));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_vals("rst");
        drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
        hist.delete();
        pend_v = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    vec_t tbl[13];
    req_t idle;
    int   g, k;
    bit   granted, seen;
    int   exp_own[4] = '{1, 1, 1, 0};

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = 32'hC0DE0000 | i;
            mmem[i] = 32'hC0DE0000 | i;
        end
        idle = mk(0, 0, 0, 0, 0);
        tbl[0]  = '{mk(0, 1, 5, 4'hF, 32'hDEADBEEF), idle, 0, 1, 0, 0, 32'h0};
        tbl[1]  = '{mk(1, 0, 5, 4'hF, 32'h0), idle, 0, 1, 0, 0, 32'h0};
        tbl[2]  = '{idle, idle, 1, 1, 1, 0, 32'hDEADBEEF};
        tbl[3]  = '{mk(0, 1, 7, 4'hF, 32'h11223344), idle, 0, 1, 0, 0, 32'h0};
        tbl[4]  = '{mk(0, 1, 7, 4'h2, 32'hAABBCCDD), idle, 0, 1, 0, 0, 32'h0};
        tbl[5]  = '{mk(1, 0, 7, 4'hF, 32'h0), idle, 0, 1, 0, 0, 32'h0};
        tbl[6]  = '{idle, idle, 1, 1, 1, 0, 32'h1122CC44};
        tbl[7]  = '{idle, mk(1, 1, 3, 4'hF, 32'h5A5A5A5A), 1, 0, 0, 0, 32'h0};
        tbl[8]  = '{idle, idle, 1, 1, 0, 0, 32'h0};
        tbl[9]  = '{idle, mk(1, 0, 3, 4'hF, 32'h0), 1, 0, 0, 0, 32'h0};
        tbl[10] = '{idle, idle, 1, 1, 0, 1, 32'h5A5A5A5A};
        tbl[11] = '{mk(1, 0, 5, 4'hF, 32'h0), mk(1, 0, 7, 4'hF, 32'h0), 1, 0, 0, 0, 32'h0};
        tbl[12] = '{idle, idle, 1, 1, 0, 1, 32'h1122CC44};

        do_reset();

        // Directed vectors: single requester, byte enables, protocol error.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].q0, tbl[i].q1, g);
            check("tbl_wait0", bus.r0_waitrequest, tbl[i].w0);
            check("tbl_wait1", bus.r1_waitrequest, tbl[i].w1);
            check("tbl_rdv0", bus.r0_readdatavalid, tbl[i].v0);
            check("tbl_rdv1", bus.r1_readdatavalid, tbl[i].v1);
            check("tbl_rdata0", bus.r0_readdata, tbl[i].v0 ? tbl[i].rd : 32'h0);
            check("tbl_rdata1", bus.r1_readdata, tbl[i].v1 ? tbl[i].rd : 32'h0);
        end

        // Continuous contention: four grants each, alternating.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(mk(1, 0, i, 4'hF, 32'h0), mk(1, 0, 32 + i, 4'hF, 32'h0), g);
            check("rr_owner", bus.r1_waitrequest ? 32'd0 : 32'd1, 32'((i / 4) % 2));
        end
        step(idle, idle, g);

        // r1 alone for a long run, then r0 joins.
        do_reset();
        repeat (10) step(idle, mk(1, 0, 9, 4'hF, 32'h0), g);
        k = 0;
        granted = 0;
        while (!granted && k < 8) begin
            step(mk(1, 0, 4, 4'hF, 32'h0), mk(1, 0, 9, 4'hF, 32'h0), g);
            k++;
            if (!bus.r0_waitrequest) granted = 1;
        end
        check("join_granted", granted, 1);
        check("join_within_max", k <= MAX_RUN, 1);
        step(idle, idle, g);

        // An idle cycle restarts the run count.
        do_reset();
        repeat (3) step(idle, mk(1, 0, 2, 4'hF, 32'h0), g);
        step(idle, idle, g);
        step(idle, mk(1, 0, 2, 4'hF, 32'h0), g);
        for (int j = 0; j < 4; j++) begin
            step(mk(1, 0, 6, 4'hF, 32'h0), mk(1, 0, 2, 4'hF, 32'h0), g);
            check("restart_owner", bus.r1_waitrequest ? 32'd0 : 32'd1, 32'(exp_own[j]));
        end
        step(idle, idle, g);

        // Reset right after a read is accepted: its data is never returned.
        do_reset();
        step(mk(1, 0, 5, 4'hF, 32'h0), idle, g);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.r0_readdatavalid || bus.r1_readdatavalid) seen = 1;
        end
        drive(idle, idle);
        hist.delete();
        pend_v = 0;
        reset_n = 1'b1;
        repeat (3) begin
            step(idle, idle, g);
            if (bus.r0_readdatavalid || bus.r1_readdatavalid) seen = 1;
        end
        check("midrst_no_valid", seen, 0);
        step(mk(1, 0, 5, 4'hF, 32'h0), idle, g);
        step(idle, idle, g);
        check("midrst_read_after", bus.r0_readdata, 32'hDEADBEEF);

        // Randomized traffic on a small address window, including protocol errors.
        for (int i = 0; i < 400; i++) begin
            req_t a, b;
            a = mk(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                   4'($urandom_range(0, 15)), $urandom);
            b = mk(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 15),
                   4'($urandom_range(0, 15)), $urandom);
            step(a, b, g);
        end
        step(idle, idle, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
